// File: rtl/axi_slave_mem.sv
// AXI3 slave memory: independent write and read burst engines over a word-organised RAM.
// Latency: AW->wready +1 cycle, last W->bvalid +1, AR->first R beat +1, then one beat per cycle.
// Backpressure: R and B payloads hold while ready is low; AW/W/AR are accepted only in the matching FSM state.
module axi_slave_mem #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awbrust,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arbrust,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Malformed burst: unsupported size, reserved type, or WRAP with a non-power-of-2 beat count.
  function automatic logic burst_err(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    burst_err = (size > 3'd2) || (burst == 2'b11) ||
                ((burst == 2'b10) && !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15)));
  endfunction

  // Address of the beat following cur; reserved bursts step like INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] cur, input logic [ADDR_W-1:0] start,
                                                  input logic [3:0] len, input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] bound;
    incr  = ADDR_W'(1) << size;
    bound = (ADDR_W'(len) + ADDR_W'(1)) << size;
    if (burst == 2'b00)
      next_addr = cur;
    else if (burst == 2'b10)
      next_addr = (start & ~(bound - ADDR_W'(1))) | ((cur + incr) & (bound - ADDR_W'(1)));
    else
      next_addr = cur + incr;
  endfunction

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    oor = (a[ADDR_W-1:AW+2] != '0);
  endfunction

  function automatic logic [AW-1:0] widx(input logic [ADDR_W-1:0] a);
    widx = a[AW+1:2];
  endfunction

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // ---------------- write path ----------------
  wstate_t           w_state, w_next;
  logic [ADDR_W-1:0] waddr, wstart;
  logic [3:0]        wlen, wcnt;
  logic [2:0]        wsize;
  logic [1:0]        wburst;
  logic              werr;
  logic              aw_hs, w_hs, b_hs, w_beat_err;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  // A beat is bad if it misses the RAM, its wlast disagrees with the beat count, or its id differs.
  assign w_beat_err = oor(waddr) || (wlast != (wcnt == wlen)) || (wid != bid);

  // Write FSM next state: leave W_DATA on the counted final beat, independent of wlast.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && (wcnt == wlen)) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM state and registered channel handshake outputs.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      w_state <= w_next;
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
    end
  end

  // Write burst context, beat address walk and response accumulation.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      bid    <= '0;
      bresp  <= 2'b00;
      waddr  <= '0;
      wstart <= '0;
      wlen   <= 4'd0;
      wsize  <= 3'd0;
      wburst <= 2'b00;
      wcnt   <= 4'd0;
      werr   <= 1'b0;
    end else if (aw_hs) begin
      bid    <= awid;
      waddr  <= awaddr;
      wstart <= awaddr;
      wlen   <= awlen;
      wsize  <= awsize;
      wburst <= awbrust;
      wcnt   <= 4'd0;
      werr   <= burst_err(awlen, awsize, awbrust);
    end else if (w_hs) begin
      waddr <= next_addr(waddr, wstart, wlen, wsize, wburst);
      wcnt  <= wcnt + 4'd1;
      werr  <= werr | w_beat_err;
      if (wcnt == wlen) bresp <= {werr | w_beat_err, 1'b0};
    end
  end

  // RAM byte writes; contents are deliberately not reset.
  always_ff @(posedge aclk) begin
    if (w_hs && !oor(waddr)) begin
      for (int b = 0; b < SW; b++)
        if (wstrb[b]) mem[widx(waddr)][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // ---------------- read path ----------------
  rstate_t           r_state, r_next;
  logic [ADDR_W-1:0] raddr, rstart, r_nxt;
  logic [3:0]        rlen, rcnt;
  logic [2:0]        rsize;
  logic [1:0]        rburst;
  logic              rberr;
  logic              ar_hs, r_hs, ar_berr;

  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  assign r_nxt   = next_addr(raddr, rstart, rlen, rsize, rburst);
  assign ar_berr = burst_err(arlen, arsize, arbrust);

  // Read FSM next state: return to idle on the accepted rlast beat.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM state and registered arready/rvalid.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_DATA);
    end
  end

  // Read beat loader: beat 0 on AR, the next beat on each non-final R handshake; held otherwise.
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      rid    <= '0;
      rdata  <= '0;
      rresp  <= 2'b00;
      rlast  <= 1'b0;
      raddr  <= '0;
      rstart <= '0;
      rlen   <= 4'd0;
      rsize  <= 3'd0;
      rburst <= 2'b00;
      rcnt   <= 4'd0;
      rberr  <= 1'b0;
    end else if (ar_hs) begin
      rid    <= arid;
      raddr  <= araddr;
      rstart <= araddr;
      rlen   <= arlen;
      rsize  <= arsize;
      rburst <= arbrust;
      rcnt   <= 4'd0;
      rberr  <= ar_berr;
      rlast  <= (arlen == 4'd0);
      rdata  <= oor(araddr) ? '0 : mem[widx(araddr)];
      rresp  <= {ar_berr | oor(araddr), 1'b0};
    end else if (r_hs && !rlast) begin
      raddr <= r_nxt;
      rcnt  <= rcnt + 4'd1;
      rlast <= ((rcnt + 4'd1) == rlen);
      rdata <= oor(r_nxt) ? '0 : mem[widx(r_nxt)];
      rresp <= {rberr | oor(r_nxt), 1'b0};
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: random and directed bursts against a word-array memory model.
// Expected responses are queued per burst and checked every cycle a valid is high.
// Ready inputs are driven always-high, random, or held low to exercise stalls.
module tb_axi_slave_mem;
  localparam int DEPTH = 1024;

  logic        aclk = 1'b0;
  logic        arst;
  logic [3:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awbrust, arbrust, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_slave_mem #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awbrust(awbrust),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arbrust(arbrust),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rexp_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl [DEPTH];
  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [33:0] rlog[$];
  logic [1:0]  last_bresp;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          rdy_mode = 0;
  bit          b_done = 0, r_done = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model address of a given beat, stepping the burst rule beat by beat.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int beat);
    logic [31:0] a, incr, bound;
    a = start;
    incr = 32'd1 << size;
    bound = (32'(len) + 32'd1) * incr;
    for (int i = 0; i < beat; i++) begin
      if (burst == 2'b10) a = (start & ~(bound - 1)) | ((a + incr) & (bound - 1));
      else if (burst != 2'b00) a = a + incr;
    end
    return a;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < DEPTH;
  endfunction

  function automatic bit bad_burst(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    return (size > 2) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Ready generator: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        1: begin rready = ($urandom_range(0, 3) != 0); bready = ($urandom_range(0, 2) != 0); end
        2: begin rready = 1'b0; bready = 1'b0; end
        default: begin rready = 1'b1; bready = 1'b1; end
      endcase
    end
  end

  // Single compare process: B and R payloads against the queued model expectations.
  initial begin
    forever begin
      @(negedge aclk);
      if (!arst) begin
        b_done = 0;
        r_done = 0;
      end else begin
        if (b_done) begin check("awready_after_b", awready, 1); b_done = 0; end
        if (r_done) begin check("arready_after_rlast", arready, 1); r_done = 0; end
        if (bvalid) begin
          if (bq.size() == 0) check("bvalid_unexpected", bvalid, 0);
          else begin
            check("bid", bid, bq[0].id);
            check("bresp", bresp, bq[0].resp);
            if (bready) begin last_bresp = bresp; void'(bq.pop_front()); b_done = 1; end
          end
        end
        if (rvalid) begin
          if (rq.size() == 0) check("rvalid_unexpected", rvalid, 0);
          else begin
            check("rid", rid, rq[0].id);
            check("rdata", rdata, rq[0].data);
            check("rresp", rresp, rq[0].resp);
            check("rlast", rlast, rq[0].last);
            if (rready) begin
              rlog.push_back({rresp, rdata});
              if (rq[0].last) r_done = 1;
              void'(rq.pop_front());
            end
          end
        end
      end
    end
  end

  // Write burst from wd/ws; beat indices wl_err/wid_err corrupt wlast/wid (-1 = none).
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int wl_err, input int wid_err, input bit gaps);
    bit err;
    int n;
    logic [31:0] a;
    err = bad_burst(len, size, burst);
    awid = id; awaddr = addr; awlen = len; awsize = size; awbrust = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge aclk); #1; n++; end
    if (n >= 100) check("aw_handshake_timeout", awready, 1);
    @(posedge aclk);
    #1;
    awvalid = 1'b0;
    check("aw_latency_awready", awready, 0);
    check("aw_latency_wready", wready, 1);
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      end
      wdata = wd[b]; wstrb = ws[b];
      wlast = (b == int'(len)) ^ (b == wl_err);
      wid = (b == wid_err) ? (id ^ 4'h1) : id;
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(posedge aclk); #1; n++; end
      if (n >= 100) check("w_handshake_timeout", wready, 1);
      @(posedge aclk);
      a = beat_addr(addr, len, size, burst, b);
      if (in_range(a)) begin
        for (int k = 0; k < 4; k++) if (ws[b][k]) mdl[a[11:2]][8*k +: 8] = wd[b][8*k +: 8];
      end else err = 1;
      if (b == wl_err || b == wid_err) err = 1;
      if (b == int'(len)) bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
      #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    check("b_latency_bvalid", bvalid, 1);
    check("b_latency_wready", wready, 0);
    n = 0;
    while (bq.size() != 0 && n < 300) begin @(posedge aclk); #1; n++; end
    if (bq.size() != 0) begin check("b_drain_timeout", bq.size(), 0); bq.delete(); end
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit berr;
    int n;
    logic [31:0] a;
    berr = bad_burst(len, size, burst);
    for (int b = 0; b <= int'(len); b++) begin
      a = beat_addr(addr, len, size, burst, b);
      rq.push_back('{id: id, data: in_range(a) ? mdl[a[11:2]] : 32'h0,
                     resp: (berr || !in_range(a)) ? 2'b10 : 2'b00, last: (b == int'(len))});
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arbrust = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(posedge aclk); #1; n++; end
    if (n >= 100) check("ar_handshake_timeout", arready, 1);
    @(posedge aclk);
    #1;
    arvalid = 1'b0;
    check("ar_latency_rvalid", rvalid, 1);
    check("ar_latency_arready", arready, 0);
    n = 0;
    while (rq.size() != 0 && n < 2000) begin @(posedge aclk); #1; n++; end
    if (rq.size() != 0) begin check("r_drain_timeout", rq.size(), 0); rq.delete(); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] wexp [4];
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          r, wl_err, wid_err;

    arst = 1'b0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awbrust = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arbrust = 0; arvalid = 0;
    #23;
    check("rst_awready", awready, 0); check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);   check("rst_bresp", bresp, 0);
    check("rst_bid", bid, 0);         check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);   check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);     check("rst_rdata", rdata, 0);
    check("rst_rid", rid, 0);
    #4 arst = 1'b1;
    #1;
    check("rel_awready_before_edge", awready, 0);
    check("rel_arready_before_edge", arready, 0);
    @(posedge aclk);
    #1;
    check("rel_awready_after_edge", awready, 1);
    check("rel_arready_after_edge", arready, 1);

    // Fill the whole RAM so every later read has a known model value.
    for (int w = 0; w < DEPTH; w += 16) begin
      for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      axi_write(4'($urandom_range(0, 15)), 32'(w * 4), 4'd15, 3'd2, 2'b01, -1, -1, 1'b0);
    end

    // INCR write then read back.
    for (int b = 0; b < 4; b++) begin wd[b] = 32'hA0 + 32'(b); ws[b] = 4'hF; end
    last_bresp = 2'bxx;
    axi_write(4'h1, 32'h10, 4'd3, 3'd2, 2'b01, -1, -1, 1'b0);
    check("incr_bresp", last_bresp, 2'b00);
    rlog.delete();
    axi_read(4'h2, 32'h10, 4'd3, 3'd2, 2'b01);
    check("incr_rd_beats", rlog.size(), 4);
    for (int i = 0; i < 4; i++) check("incr_rd_data", rlog[i], {2'b00, 32'hA0 + 32'(i)});

    // WRAP address order, pinned by literals, then read through the DUT.
    wexp = '{32'h38, 32'h3C, 32'h30, 32'h34};
    for (int i = 0; i < 4; i++) check("wrap_model_addr", beat_addr(32'h38, 4'd3, 3'd2, 2'b10, i), wexp[i]);
    rlog.delete();
    axi_read(4'h3, 32'h38, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) check("wrap_rd_data", rlog[i][31:0], mdl[wexp[i][11:2]]);

    // Byte strobes.
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_write(4'h4, 32'h0, 4'd0, 3'd2, 2'b01, -1, -1, 1'b0);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    axi_write(4'h4, 32'h0, 4'd0, 3'd2, 2'b01, -1, -1, 1'b0);
    rlog.delete();
    axi_read(4'h4, 32'h0, 4'd0, 3'd2, 2'b01);
    check("strobe_rd", rlog[0][31:0], 32'hFF22_FF44);

    // Out-of-range write: SLVERR and no aliasing onto word 0.
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    last_bresp = 2'bxx;
    axi_write(4'h5, 32'h1000, 4'd0, 3'd2, 2'b01, -1, -1, 1'b0);
    check("oor_bresp", last_bresp, 2'b10);
    rlog.delete();
    axi_read(4'h5, 32'h0, 4'd0, 3'd2, 2'b01);
    axi_read(4'h5, 32'h1000, 4'd0, 3'd2, 2'b01);
    check("oor_no_alias", rlog[0], {2'b00, 32'hFF22_FF44});
    check("oor_rd", rlog[1], {2'b10, 32'h0});

    // Unsupported read size.
    rlog.delete();
    axi_read(4'h6, 32'h40, 4'd3, 3'd3, 2'b01);
    check("size3_beats", rlog.size(), 4);
    for (int i = 0; i < 4; i++) check("size3_rresp", rlog[i][33:32], 2'b10);

    // Early wlast: SLVERR but all four beats are still consumed.
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    last_bresp = 2'bxx;
    axi_write(4'h7, 32'h80, 4'd3, 3'd2, 2'b01, 1, -1, 1'b0);
    check("early_wlast_bresp", last_bresp, 2'b10);
    axi_read(4'h7, 32'h80, 4'd3, 3'd2, 2'b01);

    // R backpressure mid-burst.
    fork
      axi_read(4'h8, 32'h100, 4'd15, 3'd2, 2'b01);
      begin
        repeat (4) @(posedge aclk);
        #1;
        rdy_mode = 2;
        repeat (6) begin @(posedge aclk); #1; check("rstall_rvalid", rvalid, 1); end
        rdy_mode = 0;
      end
    join

    // B backpressure.
    rdy_mode = 2;
    for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    fork
      axi_write(4'h9, 32'h140, 4'd1, 3'd2, 2'b01, -1, -1, 1'b0);
      begin
        int n;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge aclk); #1; n++; end
        repeat (4) begin
          check("bstall_bvalid", bvalid, 1);
          check("bstall_awready", awready, 0);
          @(posedge aclk);
          #1;
        end
        rdy_mode = 0;
      end
    join

    // Randomized bursts with random ready stalls.
    rdy_mode = 1;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 15);
      if (r == 0) addr = $urandom_range(32'h1000, 32'h10FF);
      else if (r == 1) addr = $urandom_range(32'hFC0, 32'hFFF);
      else addr = $urandom_range(0, 32'hFFF);
      len = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      size = (r < 7) ? 3'd2 : (r < 9) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      burst = (r < 4) ? 2'b01 : (r < 6) ? 2'b00 : (r < 9) ? 2'b10 : 2'($urandom_range(0, 3));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = 4'((1 << $urandom_range(1, 4)) - 1);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom_range(0, 15)); end
        wl_err  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1;
        wid_err = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : -1;
        axi_write(4'($urandom_range(0, 15)), addr, len, size, burst, wl_err, wid_err, 1'b1);
      end else begin
        axi_read(4'($urandom_range(0, 15)), addr, len, size, burst);
      end
    end
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset during beat 2 of a 4-beat write.
    awid = 4'h3; awaddr = 32'h200; awlen = 4'd3; awsize = 3'd2; awbrust = 2'b01; awvalid = 1'b1;
    while (!awready) begin @(posedge aclk); #1; end
    @(posedge aclk);
    #1;
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = 32'hC0DE_0000 + 32'(b); wstrb = 4'hF; wlast = 1'b0; wid = 4'h3; wvalid = 1'b1;
      check("rstw_wready", wready, 1);
      @(posedge aclk);
      mdl[128 + b] = wdata;
      #1;
    end
    wdata = 32'hC0DE_0002; wvalid = 1'b1;
    #2 arst = 1'b0;
    #1;
    check("midrst_awready", awready, 0); check("midrst_wready", wready, 0);
    check("midrst_bvalid", bvalid, 0);   check("midrst_bresp", bresp, 0);
    check("midrst_bid", bid, 0);         check("midrst_arready", arready, 0);
    check("midrst_rvalid", rvalid, 0);   check("midrst_rlast", rlast, 0);
    check("midrst_rresp", rresp, 0);     check("midrst_rdata", rdata, 0);
    check("midrst_rid", rid, 0);
    wvalid = 1'b0;
    bq.delete();
    rq.delete();
    @(posedge aclk);
    @(posedge aclk);
    #3 arst = 1'b1;
    #1;
    check("midrst_rel_awready_before_edge", awready, 0);
    @(posedge aclk);
    #1;
    check("midrst_rel_awready", awready, 1);
    check("midrst_rel_arready", arready, 1);
    rlog.delete();
    axi_read(4'hA, 32'h200, 4'd3, 3'd2, 2'b01);
    check("midrst_keep_beat0", rlog[0][31:0], 32'hC0DE_0000);
    check("midrst_keep_beat1", rlog[1][31:0], 32'hC0DE_0001);
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    last_bresp = 2'bxx;
    axi_write(4'hB, 32'h300, 4'd3, 3'd2, 2'b01, -1, -1, 1'b0);
    check("post_rst_bresp", last_bresp, 2'b00);
    axi_read(4'hB, 32'h300, 4'd3, 3'd2, 2'b01);

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
